capture_sequencer: RTL
======================

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter DEPTH, default 1024: samples per capture, range 2..65536.
REQ-002 Parameter TX_TIMEOUT, default 50000: clock cycles allowed per byte waiting for iTxDone.
REQ-003 iClock  in  1  sole clock; all state updates on its rising edge.
REQ-004 iReset  in  1  asynchronous reset, active-low: 0 = reset asserted.
REQ-005 iRxDone  in  1  one-cycle pulse: UART byte received; iRxData is valid in that cycle.
REQ-006 iRxData  in  8  received UART byte.
REQ-007 iTxDone  in  1  one-cycle pulse: UART finished transmitting the last byte.
REQ-008 oTxSend  out  1  one-cycle pulse: UART starts transmitting oTxData.
REQ-009 oTxData  out  8  byte to transmit; held stable from the oTxSend pulse until iTxDone.
REQ-010 oMemAddr  out  16  shared sample-memory address.
REQ-011 oMemWrite  out  1  memory write enable.
REQ-012 iMemData  in  8  memory read data; valid one cycle after the address is presented.
REQ-013 oFetchValue  out  1  one-cycle pulse: stimulus register latches iRxData.
REQ-014 oSerialReset  out  1  one-cycle pulse: UART soft reset.
REQ-015 oBusy  out  1  high in every state except IDLE and ARM.
REQ-016 oError  out  1  sticky TX-timeout flag; cleared by the next accepted 'S' command.
REQ-017 oState  out  3  state encoding per REQ-019, for debug LEDs.

Function
REQ-018 Command protocol: byte 0x53 ('S') followed by one value byte starts a capture; no other command exists.
REQ-019 State encoding: IDLE=0, ARM=1, SAMPLE=2, READ=3, WAIT_Q=4, SEND=5, WAIT_TX=6, DONE=7.
REQ-020 IDLE: iRxDone with 0x53 -> ARM and clear oError; iRxDone with any other byte -> stay in IDLE.
REQ-021 ARM: next iRxDone (any value) -> pulse oFetchValue in that same cycle, clear the address counter, go to SAMPLE.
REQ-022 SAMPLE: oMemWrite=1 and oMemAddr=counter each cycle; counter increments each cycle.
REQ-023 SAMPLE exit: in the cycle the counter equals DEPTH-1, perform the final write, clear the counter, go to READ. Exactly DEPTH writes occur, at addresses 0..DEPTH-1.
REQ-024 READ: present oMemAddr=counter with oMemWrite=0, go to WAIT_Q.
REQ-025 WAIT_Q: wait one cycle for the memory read latency, go to SEND.
REQ-026 SEND: register iMemData into oTxData, pulse oTxSend once, load the timeout counter with TX_TIMEOUT, go to WAIT_TX.
REQ-027 WAIT_TX, on iTxDone: if counter = DEPTH-1 go to DONE; otherwise increment the counter and go to READ.
REQ-028 WAIT_TX, no iTxDone: decrement the timeout counter. On reaching 0, set oError and go to DONE, aborting the transfer.
REQ-029 DONE: pulse oSerialReset for one cycle, go to IDLE.
REQ-030 Outside ARM, iRxDone bytes received while oBusy=1 are discarded with no other effect.
REQ-031 oMemWrite is 0 in every state except SAMPLE; oTxSend is never asserted in two consecutive cycles.
REQ-032 Address counter is 16 bits; the DEPTH-1 compare prevents wrap. DEPTH=65536 ends at 0xFFFF without wrapping to 0 mid-capture.
REQ-033 If iTxDone and the timeout expiry fall in the same cycle, iTxDone wins: no error is flagged.
REQ-034 Maximum bytes sent per capture = DEPTH. Bytes are sent in ascending address order.

Reset
REQ-035 While iReset=0: state=IDLE, counters=0, oTxData=0x00, oError=0, every pulse output=0, oMemAddr=0, oMemWrite=0.
REQ-036 Reset applied mid-operation aborts immediately. There is no oSerialReset pulse on recovery; the next capture requires a fresh 'S' command.
REQ-037 First state transition occurs on the first rising edge after iReset returns to 1.

Verification (DEPTH=4, TX_TIMEOUT=20, 1-cycle-latency memory model)
REQ-038 Rx 0x53 then 0x2A -> one oFetchValue pulse with the 0x2A byte; 4 write cycles at addresses 0,1,2,3; 4 oTxSend pulses carrying mem[0..3] in order; one oSerialReset pulse; return to IDLE.
REQ-039 Rx 0x41 while in IDLE -> oState stays 0; no output pulse.
REQ-040 Rx 0x53 during WAIT_TX -> byte ignored; the capture continues unchanged.
REQ-041 Withhold iTxDone after the 2nd byte -> oError=1 after 20 cycles, DONE, then IDLE; the next 'S' command clears oError.
REQ-042 iTxDone coincident with the timeout expiry -> oError=0; the transfer continues.
REQ-043 Assert iReset=0 during SAMPLE at address 2 -> all outputs reach reset values asynchronously; a full capture afterwards runs normally.

Source files
------------

// File: rtl/capture_sequencer_if.sv
// UART, sample-memory and status signals of the capture sequencer.
// master = the sequencer, slave = UART/memory/stimulus side.
interface capture_sequencer_if;
    logic        iRxDone;
    logic [7:0]  iRxData;
    logic        iTxDone;
    logic        oTxSend;
    logic [7:0]  oTxData;
    logic [15:0] oMemAddr;
    logic        oMemWrite;
    logic [7:0]  iMemData;
    logic        oFetchValue;
    logic        oSerialReset;
    logic        oBusy;
    logic        oError;
    logic [2:0]  oState;

    modport master (
        input  iRxDone, iRxData, iTxDone, iMemData,
        output oTxSend, oTxData, oMemAddr, oMemWrite, oFetchValue,
               oSerialReset, oBusy, oError, oState
    );

    modport slave (
        output iRxDone, iRxData, iTxDone, iMemData,
        input  oTxSend, oTxData, oMemAddr, oMemWrite, oFetchValue,
               oSerialReset, oBusy, oError, oState
    );
endinterface

// File: rtl/capture_sequencer.sv
// Purpose: 'S'+value command arms a DEPTH-sample capture, then streams the samples out over UART.
// Latency: fetch pulse same cycle as the value byte; 3 cycles + UART time per byte sent.
// Backpressure: waits on iTxDone per byte, bounded by TX_TIMEOUT cycles (sticky oError on expiry).
module capture_sequencer #(
    parameter int DEPTH      = 1024,
    parameter int TX_TIMEOUT = 50000
) (
    input  logic                 iClock,
    input  logic                 iReset,
    capture_sequencer_if.master  bus
);
    localparam int          TW   = $clog2(TX_TIMEOUT + 1);
    localparam logic [15:0] LAST = 16'(DEPTH - 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TX_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        SAMPLE  = 3'd2,
        READ    = 3'd3,
        WAIT_Q  = 3'd4,
        SEND    = 3'd5,
        WAIT_TX = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t        state;
    logic [15:0]   addr;
    logic [TW-1:0] timeout;
    logic [7:0]    tx_data;
    logic          tx_send;
    logic          mem_write;
    logic          serial_reset;
    logic          error;

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state        <= IDLE;
            addr         <= '0;
            timeout      <= '0;
            tx_data      <= 8'h00;
            tx_send      <= 1'b0;
            mem_write    <= 1'b0;
            serial_reset <= 1'b0;
            error        <= 1'b0;
        end else begin
            tx_send      <= 1'b0;
            serial_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iRxDone && bus.iRxData == 8'h53) begin
                        error <= 1'b0;
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (bus.iRxDone) begin
                        addr      <= '0;
                        mem_write <= 1'b1;
                        state     <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    // Compare against the last address so DEPTH=65536 never wraps mid-capture.
                    if (addr == LAST) begin
                        addr      <= '0;
                        mem_write <= 1'b0;
                        state     <= READ;
                    end else begin
                        addr <= addr + 16'd1;
                    end
                end
                READ:   state <= WAIT_Q;
                WAIT_Q: state <= SEND;
                SEND: begin
                    tx_data <= bus.iMemData;
                    tx_send <= 1'b1;
                    timeout <= TO_LOAD;
                    state   <= WAIT_TX;
                end
                WAIT_TX: begin
                    // iTxDone takes priority over a timeout expiring in the same cycle.
                    if (bus.iTxDone) begin
                        if (addr == LAST) begin
                            serial_reset <= 1'b1;
                            state        <= DONE;
                        end else begin
                            addr  <= addr + 16'd1;
                            state <= READ;
                        end
                    end else if (timeout <= TW'(1)) begin
                        timeout      <= '0;
                        error        <= 1'b1;
                        serial_reset <= 1'b1;
                        state        <= DONE;
                    end else begin
                        timeout <= timeout - TW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oFetchValue  = (state == ARM) && bus.iRxDone;
    assign bus.oTxSend      = tx_send;
    assign bus.oTxData      = tx_data;
    assign bus.oMemAddr     = addr;
    assign bus.oMemWrite    = mem_write;
    assign bus.oSerialReset = serial_reset;
    assign bus.oError       = error;
    assign bus.oState       = state;
    assign bus.oBusy        = (state != IDLE) && (state != ARM);
endmodule
